// File: rtl/gshare_branch_predictor_if.sv
// Lookup/train/perf-counter bundle between the pipeline (master) and the gshare predictor (slave).
interface gshare_branch_predictor_if #(
    parameter int XLEN     = 32,
    parameter int PHT_W    = 6,
    parameter int GHR_BITS = 6,
    parameter int CNT_W    = 32
);
    logic                lookup_valid;
    logic [XLEN-1:0]     lookup_pc;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_target;
    logic                pred_hit;
    logic [PHT_W-1:0]    pred_idx;
    logic [GHR_BITS-1:0] pred_ghr;

    logic                upd_valid;
    logic [XLEN-1:0]     upd_pc;
    logic [PHT_W-1:0]    upd_idx;
    logic [GHR_BITS-1:0] upd_ghr;
    logic                upd_taken;
    logic [XLEN-1:0]     upd_target;
    logic                upd_mispredict;

    logic [CNT_W-1:0]    branch_count;
    logic [CNT_W-1:0]    mispred_count;

    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_idx, upd_ghr, upd_taken, upd_target, upd_mispredict,
        input  pred_taken, pred_target, pred_hit, pred_idx, pred_ghr,
        input  branch_count, mispred_count
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_idx, upd_ghr, upd_taken, upd_target, upd_mispredict,
        output pred_taken, pred_target, pred_hit, pred_idx, pred_ghr,
        output branch_count, mispred_count
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor + direct-mapped BTB with speculative GHR and saturating perf counters.
// Lookup is combinational (zero latency); training lands on the next rising edge; never stalls.
module gshare_branch_predictor #(
    parameter int XLEN        = 32,
    parameter int PHT_ENTRIES = 64,
    parameter int GHR_BITS    = 6,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    gshare_branch_predictor_if.slave bp
);
    localparam int PHT_W = $clog2(PHT_ENTRIES);
    localparam int BTB_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - BTB_W - 2;

    logic [1:0]             pht_q     [PHT_ENTRIES];
    logic [1:0]             pht_d     [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_vld_q;
    logic [BTB_ENTRIES-1:0] btb_vld_d;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       btb_tag_d [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_tgt_d [BTB_ENTRIES];
    logic [GHR_BITS-1:0]    ghr_q;
    logic [GHR_BITS-1:0]    ghr_d;
    logic [CNT_W-1:0]       br_cnt_q;
    logic [CNT_W-1:0]       br_cnt_d;
    logic [CNT_W-1:0]       mis_cnt_q;
    logic [CNT_W-1:0]       mis_cnt_d;

    logic [PHT_W-1:0] lk_idx;
    logic [BTB_W-1:0] lk_bidx;
    logic             lk_hit;
    logic             lk_taken;
    logic [BTB_W-1:0] up_bidx;
    logic             unused_bits;

    assign unused_bits = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0], bp.upd_ghr[GHR_BITS-1]};

    // Lookup reads registered state only, so a same-cycle update is never bypassed.
    always_comb begin
        lk_idx   = bp.lookup_pc[PHT_W+1:2] ^ PHT_W'(ghr_q);
        lk_bidx  = bp.lookup_pc[BTB_W+1:2];
        lk_hit   = btb_vld_q[lk_bidx] && (btb_tag_q[lk_bidx] == bp.lookup_pc[XLEN-1:BTB_W+2]);
        lk_taken = lk_hit && pht_q[lk_idx][1];
    end

    assign bp.pred_idx      = lk_idx;
    assign bp.pred_ghr      = ghr_q;
    assign bp.pred_hit      = lk_hit;
    assign bp.pred_taken    = lk_taken;
    assign bp.pred_target   = lk_hit ? btb_tgt_q[lk_bidx] : '0;
    assign bp.branch_count  = br_cnt_q;
    assign bp.mispred_count = mis_cnt_q;

    assign up_bidx = bp.upd_pc[BTB_W+1:2];

    always_comb begin
        pht_d     = pht_q;
        btb_vld_d = btb_vld_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (bp.upd_valid) begin
            if (bp.upd_taken) begin
                if (pht_q[bp.upd_idx] != 2'b11) pht_d[bp.upd_idx] = pht_q[bp.upd_idx] + 2'd1;
                btb_vld_d[up_bidx] = 1'b1;
                btb_tag_d[up_bidx] = bp.upd_pc[XLEN-1:BTB_W+2];
                btb_tgt_d[up_bidx] = bp.upd_target;
            end else if (pht_q[bp.upd_idx] != 2'b00) begin
                pht_d[bp.upd_idx] = pht_q[bp.upd_idx] - 2'd1;
            end
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
            if (bp.upd_mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 1'b1;
        end
    end

    // A mispredict repairs history from the branch's checkpoint and drops any concurrent lookup shift.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.upd_valid && bp.upd_mispredict) begin
            ghr_d = GHR_BITS'({bp.upd_ghr, bp.upd_taken});
        end else if (bp.lookup_valid && lk_hit) begin
            ghr_d = GHR_BITS'({ghr_q, lk_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
            btb_vld_q <= '0;
            ghr_q     <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            pht_q     <= pht_d;
            btb_vld_q <= btb_vld_d;
            btb_tag_q <= btb_tag_d;
            btb_tgt_q <= btb_tgt_d;
            ghr_q     <= ghr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: abstract table model checked every cycle plus literal pins.
module tb_gshare_branch_predictor;
    localparam int XLEN        = 32;
    localparam int PHT_ENTRIES = 64;
    localparam int PHT_W       = 6;
    localparam int GHR_BITS    = 6;
    localparam int BTB_ENTRIES = 16;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.XLEN(XLEN), .PHT_W(PHT_W), .GHR_BITS(GHR_BITS), .CNT_W(CNT_W)) bp ();

    gshare_branch_predictor #(
        .XLEN(XLEN), .PHT_ENTRIES(PHT_ENTRIES), .GHR_BITS(GHR_BITS),
        .BTB_ENTRIES(BTB_ENTRIES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp(bp)
    );

    int tests = 0;
    int fails = 0;

    int          m_pht [PHT_ENTRIES];
    bit          m_bv  [BTB_ENTRIES];
    int unsigned m_tag [BTB_ENTRIES];
    int unsigned m_tgt [BTB_ENTRIES];
    int          m_ghr, m_bc, m_mc;
    bit          e_hit, e_taken;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PHT_ENTRIES; i++) m_pht[i] = 1;
        for (int i = 0; i < BTB_ENTRIES; i++) m_bv[i] = 1'b0;
        m_ghr = 0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    task automatic model_update();
        int i;
        int bi;
        if (rst) begin
            model_reset();
        end else begin
            if (bp.upd_valid) begin
                i = int'(bp.upd_idx);
                if (bp.upd_taken) begin
                    m_pht[i] = (m_pht[i] == 3) ? 3 : m_pht[i] + 1;
                    bi = int'((bp.upd_pc >> 2) % BTB_ENTRIES);
                    m_bv[bi]  = 1'b1;
                    m_tag[bi] = bp.upd_pc >> 6;
                    m_tgt[bi] = bp.upd_target;
                end else begin
                    m_pht[i] = (m_pht[i] == 0) ? 0 : m_pht[i] - 1;
                end
                m_bc = (m_bc == CNT_MAX) ? CNT_MAX : m_bc + 1;
                if (bp.upd_mispredict) m_mc = (m_mc == CNT_MAX) ? CNT_MAX : m_mc + 1;
            end
            if (bp.upd_valid && bp.upd_mispredict)
                m_ghr = ((int'(bp.upd_ghr) * 2) + int'(bp.upd_taken)) % (1 << GHR_BITS);
            else if (bp.lookup_valid && e_hit)
                m_ghr = ((m_ghr * 2) + int'(e_taken)) % (1 << GHR_BITS);
        end
    endtask

    // Compare all outputs mid-cycle against the model, then advance the model on the edge.
    task automatic cycle();
        int unsigned pc;
        int unsigned idx;
        int unsigned bi;
        @(negedge clk);
        pc      = bp.lookup_pc;
        idx     = ((pc >> 2) % PHT_ENTRIES) ^ m_ghr;
        bi      = (pc >> 2) % BTB_ENTRIES;
        e_hit   = m_bv[bi] && (m_tag[bi] == (pc >> 6));
        e_taken = e_hit && (m_pht[idx] >= 2);
        chk("pred_idx", 64'(bp.pred_idx), 64'(idx));
        chk("pred_ghr", 64'(bp.pred_ghr), 64'(m_ghr));
        chk("pred_hit", 64'(bp.pred_hit), 64'(e_hit));
        chk("pred_taken", 64'(bp.pred_taken), 64'(e_taken));
        chk("pred_target", 64'(bp.pred_target), e_hit ? 64'(m_tgt[bi]) : 64'd0);
        chk("branch_count", 64'(bp.branch_count), 64'(m_bc));
        chk("mispred_count", 64'(bp.mispred_count), 64'(m_mc));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                         input logic [5:0] uidx, input logic [5:0] ughr, input bit ut,
                         input logic [31:0] utgt, input bit um);
        bp.lookup_valid   = lv;
        bp.lookup_pc      = lpc;
        bp.upd_valid      = uv;
        bp.upd_pc         = upc;
        bp.upd_idx        = uidx;
        bp.upd_ghr        = ughr;
        bp.upd_taken      = ut;
        bp.upd_target     = utgt;
        bp.upd_mispredict = um;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 32'h0, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state
        drive(1, 32'h40, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        chk("s1_idx", 64'(bp.pred_idx), 64'h10);
        chk("s1_hit", 64'(bp.pred_hit), 64'd0);
        chk("s1_taken", 64'(bp.pred_taken), 64'd0);
        chk("s1_target", 64'(bp.pred_target), 64'd0);
        chk("s1_ghr", 64'(bp.pred_ghr), 64'd0);
        chk("s1_bc", 64'(bp.branch_count), 64'd0);
        chk("s1_mc", 64'(bp.mispred_count), 64'd0);
        cycle();

        // Two taken trainings saturate the counter and allocate the BTB
        drive(0, 32'h40, 1, 32'h40, 6'h10, 6'h0, 1, 32'h80, 0);
        cycle();
        cycle();
        drive(0, 32'h40, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        chk("s2_hit", 64'(bp.pred_hit), 64'd1);
        chk("s2_taken", 64'(bp.pred_taken), 64'd1);
        chk("s2_target", 64'(bp.pred_target), 64'h80);
        chk("s2_bc", 64'(bp.branch_count), 64'd2);
        cycle();

        // Not-taken trainings walk the counter down and saturate at 00
        drive(0, 32'h40, 1, 32'h40, 6'h10, 6'h0, 0, 32'h0, 0);
        cycle();
        chk("s3_weak_taken", 64'(bp.pred_taken), 64'd1);
        repeat (4) cycle();
        drive(0, 32'h40, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        chk("s3_hit", 64'(bp.pred_hit), 64'd1);
        chk("s3_taken", 64'(bp.pred_taken), 64'd0);
        chk("s3_bc", 64'(bp.branch_count), 64'd7);
        cycle();

        // Train pc 0x48 at idx 0x12 and 0x13, then three hit lookups (T, T, N)
        drive(0, 32'h48, 1, 32'h48, 6'h12, 6'h0, 1, 32'h200, 0);
        cycle();
        cycle();
        drive(0, 32'h48, 1, 32'h48, 6'h13, 6'h0, 1, 32'h200, 0);
        cycle();
        cycle();
        drive(1, 32'h48, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        chk("s4_l1_ghr", 64'(bp.pred_ghr), 64'd0);
        chk("s4_l1_taken", 64'(bp.pred_taken), 64'd1);
        chk("s4_l1_target", 64'(bp.pred_target), 64'h200);
        cycle();
        chk("s4_l2_ghr", 64'(bp.pred_ghr), 64'd1);
        chk("s4_l2_taken", 64'(bp.pred_taken), 64'd1);
        cycle();
        chk("s4_l3_ghr", 64'(bp.pred_ghr), 64'd3);
        chk("s4_l3_taken", 64'(bp.pred_taken), 64'd0);
        cycle();
        chk("s4_ghr_after", 64'(bp.pred_ghr), 64'd6);
        // Mispredict with a concurrent hit lookup: checkpoint restore wins
        drive(1, 32'h48, 1, 32'h48, 6'h12, 6'b000001, 1, 32'h200, 1);
        cycle();
        drive(0, 32'h48, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        chk("s4_ghr_restored", 64'(bp.pred_ghr), 64'b000011);
        chk("s4_mc", 64'(bp.mispred_count), 64'd1);
        chk("s4_bc", 64'(bp.branch_count), 64'd12);
        cycle();

        // Reset mid-training; the concurrent update must be discarded
        drive(1, 32'h40, 1, 32'h40, 6'h10, 6'h0, 1, 32'h80, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(0, 32'h48, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        chk("s5_hit", 64'(bp.pred_hit), 64'd0);
        chk("s5_taken", 64'(bp.pred_taken), 64'd0);
        chk("s5_target", 64'(bp.pred_target), 64'd0);
        chk("s5_ghr", 64'(bp.pred_ghr), 64'd0);
        chk("s5_idx", 64'(bp.pred_idx), 64'h12);
        chk("s5_bc", 64'(bp.branch_count), 64'd0);
        chk("s5_mc", 64'(bp.mispred_count), 64'd0);
        cycle();
        drive(0, 32'h40, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        chk("s5_no_alloc", 64'(bp.pred_hit), 64'd0);
        cycle();

        // Counter saturation
        drive(0, 32'h40, 1, 32'h50, 6'h14, 6'h0, 0, 32'h0, 0);
        repeat (14) cycle();
        chk("s6_bc_max_m1", 64'(bp.branch_count), 64'd14);
        cycle();
        cycle();
        chk("s6_bc_sat", 64'(bp.branch_count), 64'd15);
        drive(0, 32'h40, 1, 32'h50, 6'h14, 6'b000010, 0, 32'h0, 1);
        repeat (3) cycle();
        chk("s6_mc", 64'(bp.mispred_count), 64'd3);
        chk("s6_bc_hold", 64'(bp.branch_count), 64'd15);
        chk("s6_ghr", 64'(bp.pred_ghr), 64'b000100);
        // Mispredict flag without upd_valid is ignored
        drive(0, 32'h40, 0, 32'h50, 6'h14, 6'b111111, 1, 32'h0, 1);
        cycle();
        chk("s6_ign_mc", 64'(bp.mispred_count), 64'd3);
        chk("s6_ign_ghr", 64'(bp.pred_ghr), 64'b000100);
        drive(0, 32'h40, 1, 32'h50, 6'h14, 6'b000010, 0, 32'h0, 1);
        repeat (13) cycle();
        chk("s6_mc_sat", 64'(bp.mispred_count), 64'd15);
        drive(0, 32'h40, 0, 32'h0, 6'h0, 6'h0, 0, 32'h0, 0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
